// File: rtl/trees_burst_scheduler_if.sv
// trees_burst_scheduler_if
//   Bundles the job request, accelerator configuration/completion and job
//   status signals of the tree-ensemble burst scheduler.
//   master : host + accelerator side (drives job request and acc_done)
//   slave  : the scheduler itself
interface trees_burst_scheduler_if;
    // job request from host-side control registers
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_n_samples;
    logic        job_load_trees;
    // accelerator configuration / completion
    logic        acc_conf_done;
    logic [31:0] acc_load_trees;
    logic [31:0] acc_burst_len;
    logic        acc_done;
    // job progress / status
    logic [31:0] sample_base;
    logic [15:0] bursts_done;
    logic        busy;
    logic        job_done;
    logic        job_error;

    modport master (
        output job_valid, job_n_samples, job_load_trees, acc_done,
        input  job_ready, acc_conf_done, acc_load_trees, acc_burst_len,
               sample_base, bursts_done, busy, job_done, job_error
    );

    modport slave (
        input  job_valid, job_n_samples, job_load_trees, acc_done,
        output job_ready, acc_conf_done, acc_load_trees, acc_burst_len,
               sample_base, bursts_done, busy, job_done, job_error
    );
endinterface

// File: rtl/trees_burst_scheduler.sv
// trees_burst_scheduler
//   Job-level sequencer for the tree-ensemble DMA accelerator. Accepts one
//   inference job, optionally issues a tree-load run, then splits the sample
//   count into runs of at most MAX_BURST samples. Each run is started with a
//   one-cycle acc_conf_done pulse and ends on acc_done.
//
// Ports
//   clk   : clock
//   rst   : asynchronous reset, active low
//   bus   : trees_burst_scheduler_if.slave
//           job_valid/job_ready/job_n_samples/job_load_trees : job request
//           acc_conf_done/acc_load_trees/acc_burst_len       : run config
//           acc_done                                         : run completion
//           sample_base/bursts_done/busy/job_done/job_error  : status
//
// Optional feature
//   TREES_SCHED_TIMEOUT_EN : per-run watchdog of TIMEOUT_CYCLES cycles; on
//   expiry the job ends with job_error = 1. Undefined: no watchdog,
//   job_error tied low.
//
// All outputs are registered. Their next values are decoded from the
// next state, so e.g. acc_conf_done is high exactly while in a CFG state.
module trees_burst_scheduler #(
    parameter int unsigned MAX_BURST      = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    trees_burst_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CFG,
        S_LOAD_WAIT,
        S_BURST_CFG,
        S_BURST_WAIT,
        S_FINISH
    } state_t;

    localparam logic [31:0] MAX_B = 32'(MAX_BURST);

    function automatic logic [31:0] f_min_burst(input logic [31:0] rem);
        return (rem < MAX_B) ? rem : MAX_B;
    endfunction

    state_t      r_state,       w_next;
    logic [31:0] r_remaining,   w_remaining;
    logic [31:0] r_burst_len,   w_burst_len;
    logic        r_load_trees,  w_load_trees;
    logic        r_conf_done,   w_conf_done;
    logic [31:0] r_sample_base, w_sample_base;
    logic [15:0] r_bursts_done, w_bursts_done;
    logic        r_job_done,    w_job_done;
    logic        r_job_ready,   w_job_ready;
    logic        r_busy,        w_busy;

    logic        w_accept;
    logic        w_waiting;
    logic        w_timeout;

    assign w_accept  = (r_state == S_IDLE) && bus.job_valid && r_job_ready;
    assign w_waiting = (r_state == S_LOAD_WAIT) || (r_state == S_BURST_WAIT);

    // ---------------------------------------------------------------
    // Next state / next register values
    // ---------------------------------------------------------------
    always_comb begin
        w_next        = r_state;
        w_remaining   = r_remaining;
        w_burst_len   = r_burst_len;
        w_load_trees  = r_load_trees;
        w_sample_base = r_sample_base;
        w_bursts_done = r_bursts_done;
        w_conf_done   = 1'b0;
        w_job_done    = 1'b0;
        w_job_ready   = 1'b0;
        w_busy        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_remaining   = bus.job_n_samples;
                    w_sample_base = '0;
                    w_bursts_done = '0;
                    if (bus.job_load_trees)
                        w_next = S_LOAD_CFG;
                    else if (bus.job_n_samples != 32'd0)
                        w_next = S_BURST_CFG;
                    else
                        w_next = S_FINISH;
                end
            end
            S_LOAD_CFG:  w_next = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                if (bus.acc_done)
                    w_next = (r_remaining != 32'd0) ? S_BURST_CFG : S_FINISH;
                else if (w_timeout)
                    w_next = S_FINISH;
            end
            S_BURST_CFG: w_next = S_BURST_WAIT;
            S_BURST_WAIT: begin
                if (bus.acc_done) begin
                    w_remaining   = r_remaining - r_burst_len;
                    w_sample_base = r_sample_base + r_burst_len;
                    w_bursts_done = r_bursts_done + 16'd1;
                    w_next = (w_remaining == 32'd0) ? S_FINISH : S_BURST_CFG;
                end else if (w_timeout) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase

        // Output decode from the state being entered; run config is
        // loaded on CFG entry and held for the whole run, cleared at job end.
        case (w_next)
            S_LOAD_CFG: begin
                w_conf_done  = 1'b1;
                w_load_trees = 1'b1;
                w_burst_len  = '0;
            end
            S_BURST_CFG: begin
                w_conf_done  = 1'b1;
                w_load_trees = 1'b0;
                w_burst_len  = f_min_burst(w_remaining);
            end
            S_FINISH: begin
                w_job_done   = 1'b1;
                w_load_trees = 1'b0;
                w_burst_len  = '0;
            end
            default: ;
        endcase

        w_job_ready = (w_next == S_IDLE);
        w_busy      = (w_next != S_IDLE);
    end

    // ---------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_remaining   <= '0;
            r_burst_len   <= '0;
            r_load_trees  <= 1'b0;
            r_conf_done   <= 1'b0;
            r_sample_base <= '0;
            r_bursts_done <= '0;
            r_job_done    <= 1'b0;
            r_job_ready   <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_remaining   <= w_remaining;
            r_burst_len   <= w_burst_len;
            r_load_trees  <= w_load_trees;
            r_conf_done   <= w_conf_done;
            r_sample_base <= w_sample_base;
            r_bursts_done <= w_bursts_done;
            r_job_done    <= w_job_done;
            r_job_ready   <= w_job_ready;
            r_busy        <= w_busy;
        end
    end

    // ---------------------------------------------------------------
    // Per-run watchdog
    // ---------------------------------------------------------------
`ifdef TREES_SCHED_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    logic [31:0] r_wait_cnt;
    logic        r_job_error;

    // Counter is 0 in the first waiting cycle; it fires when the wait has
    // lasted TIMEOUT_CYCLES cycles without acc_done.
    assign w_timeout = (r_wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt  <= '0;
            r_job_error <= 1'b0;
        end else begin
            if ((r_state == S_LOAD_CFG) || (r_state == S_BURST_CFG))
                r_wait_cnt <= '0;
            else if (w_waiting)
                r_wait_cnt <= r_wait_cnt + 32'd1;

            if (w_accept)
                r_job_error <= 1'b0;
            else if (w_waiting && !bus.acc_done && w_timeout)
                r_job_error <= 1'b1;
        end
    end

    assign bus.job_error = r_job_error;
`else
    logic [31:0] w_unused_timeout;
    logic        w_unused_waiting;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_unused_waiting = w_waiting;
    assign w_timeout        = 1'b0;
    assign bus.job_error    = 1'b0;
`endif

    assign bus.job_ready      = r_job_ready;
    assign bus.acc_conf_done  = r_conf_done;
    assign bus.acc_load_trees = {31'b0, r_load_trees};
    assign bus.acc_burst_len  = r_burst_len;
    assign bus.sample_base    = r_sample_base;
    assign bus.bursts_done    = r_bursts_done;
    assign bus.busy           = r_busy;
    assign bus.job_done       = r_job_done;

endmodule

// File: tb/tb_trees_burst_scheduler.sv
// Directed bench for trees_burst_scheduler. A job model pushes the expected
// runs and job completion to scoreboard queues when each job is submitted;
// a monitor pops and compares on every acc_conf_done / job_done pulse. An
// accelerator model answers each configuration pulse after acc_lat cycles.
module tb_trees_burst_scheduler;

    localparam int unsigned MAXB = 5000;
`ifdef TREES_SCHED_TIMEOUT_EN
    localparam int unsigned TO = 100;
`else
    localparam int unsigned TO = 1000000;
`endif

    typedef struct {
        logic        load;
        logic [31:0] len;
        logic [31:0] base;
        logic [15:0] bursts;
        logic        after;   // preceded by an acc_done sample
    } run_t;

    typedef struct {
        logic        err;
        logic [31:0] base;
        logic [15:0] bursts;
        logic        after;
    } done_t;

    logic clk;
    logic rst;
    trees_burst_scheduler_if bus ();

    trees_burst_scheduler #(.MAX_BURST(MAXB), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    run_t  run_q[$];
    done_t done_q[$];

    logic auto_acc = 1'b0;
    logic man_acc  = 1'b0;
    logic acc_auto = 1'b0;
    int   acc_lat  = 20;
    logic prev_acc = 1'b0;

    assign bus.acc_done = auto_acc | man_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected runs (and optionally completion) of one job.
    task automatic expect_job(input int unsigned n, input bit load, input bit with_done);
        int unsigned rem, len, base;
        int unsigned cnt;
        run_t r;
        done_t d;
        rem = n; base = 0; cnt = 0;
        if (load) begin
            r = '{load: 1'b1, len: 32'd0, base: 32'd0, bursts: 16'd0, after: 1'b0};
            run_q.push_back(r);
        end
        while (rem != 0) begin
            len = (rem < MAXB) ? rem : MAXB;
            r = '{load: 1'b0, len: len, base: base, bursts: 16'(cnt), after: (load || cnt > 0)};
            run_q.push_back(r);
            rem -= len; base += len; cnt++;
        end
        if (with_done) begin
            d = '{err: 1'b0, base: base, bursts: 16'(cnt), after: (load || n != 0)};
            done_q.push_back(d);
        end
    endtask

    task automatic submit(input logic [31:0] n, input logic load);
        @(negedge clk);
        bus.job_valid = 1'b1; bus.job_n_samples = n; bus.job_load_trees = load;
        @(negedge clk);
        bus.job_valid = 1'b0;
        chk("accept_ready_low", 32'(bus.job_ready), 32'd0);
        chk("accept_busy", 32'(bus.busy), 32'd1);
        chk("first_conf", 32'(bus.acc_conf_done), 32'(load || n != 0));
        chk("first_done", 32'(bus.job_done), 32'(!load && n == 0));
    endtask

    task automatic wait_done(input int st, input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            if (n_done != st) break;
            @(posedge clk); #2;
        end
        chk(tag, 32'(n_done - st), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"},  32'(bus.job_ready), 32'd1);
        chk({tag, "_busy"},   32'(bus.busy), 32'd0);
        chk({tag, "_conf"},   32'(bus.acc_conf_done), 32'd0);
        chk({tag, "_load"},   bus.acc_load_trees, 32'd0);
        chk({tag, "_len"},    bus.acc_burst_len, 32'd0);
        chk({tag, "_base"},   bus.sample_base, 32'd0);
        chk({tag, "_bursts"}, 32'(bus.bursts_done), 32'd0);
        chk({tag, "_jdone"},  32'(bus.job_done), 32'd0);
        chk({tag, "_jerr"},   32'(bus.job_error), 32'd0);
    endtask

    // acc_done as seen by the DUT at the latest rising edge
    initial forever begin
        @(posedge clk);
        prev_acc = bus.acc_done;
    end

    // Accelerator model
    initial begin : acc_model
        forever begin
            @(negedge clk);
            while (acc_auto && bus.acc_conf_done === 1'b1) begin
                for (int i = 0; i < acc_lat && acc_auto; i++) @(negedge clk);
                if (acc_auto) begin
                    auto_acc = 1'b1;
                    @(negedge clk);
                    auto_acc = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        run_t  r;
        done_t d;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.acc_conf_done === 1'b1) begin
                chk("run_expected", 32'(run_q.size() != 0), 32'd1);
                if (run_q.size() != 0) begin
                    r = run_q.pop_front();
                    chk("run_load_trees", bus.acc_load_trees, {31'b0, r.load});
                    chk("run_burst_len", bus.acc_burst_len, r.len);
                    chk("run_sample_base", bus.sample_base, r.base);
                    chk("run_bursts_done", 32'(bus.bursts_done), 32'(r.bursts));
                    chk("run_latency", 32'(prev_acc), 32'(r.after));
                end
            end
            if (rst === 1'b1 && bus.job_done === 1'b1) begin
                n_done++;
                chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    d = done_q.pop_front();
                    chk("done_job_error", 32'(bus.job_error), 32'(d.err));
                    chk("done_sample_base", bus.sample_base, d.base);
                    chk("done_bursts_done", 32'(bus.bursts_done), 32'(d.bursts));
                    chk("done_latency", 32'(prev_acc), 32'(d.after));
                    chk("done_ready_low", 32'(bus.job_ready), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : stim
        int st;
        int cnt;
        bus.job_valid = 1'b0; bus.job_n_samples = '0; bus.job_load_trees = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b1;
        @(negedge clk);

        // 12000 samples, no load: 5000/5000/2000; stray job_valid mid-run
        acc_auto = 1'b1; acc_lat = 20;
        expect_job(12000, 0, 1);
        st = n_done;
        submit(32'd12000, 1'b0);
        repeat (5) @(negedge clk);
        bus.job_valid = 1'b1; bus.job_n_samples = 32'd3; bus.job_load_trees = 1'b1;
        @(negedge clk);
        bus.job_valid = 1'b0;
        wait_done(st, 400, "done_12000");
        @(negedge clk);
        chk("idle_after_12000", 32'(bus.job_ready), 32'd1);

        // tree load only
        expect_job(0, 1, 1);
        st = n_done;
        submit(32'd0, 1'b1);
        wait_done(st, 100, "done_load_only");

        // zero samples, no load
        expect_job(0, 0, 1);
        st = n_done;
        submit(32'd0, 1'b0);
        wait_done(st, 10, "done_zero");

        // exact MAX_BURST, then MAX_BURST+1
        expect_job(5000, 0, 1);
        st = n_done;
        submit(32'd5000, 1'b0);
        wait_done(st, 100, "done_5000");
        expect_job(5001, 0, 1);
        st = n_done;
        submit(32'd5001, 1'b0);
        wait_done(st, 200, "done_5001");

        // acc_done in IDLE is ignored
        acc_auto = 1'b0;
        repeat (2) @(negedge clk);
        man_acc = 1'b1;
        @(negedge clk);
        man_acc = 1'b0;
        @(negedge clk);
        chk("idle_acc_busy", 32'(bus.busy), 32'd0);
        chk("idle_acc_ready", 32'(bus.job_ready), 32'd1);
        chk("idle_acc_bursts", 32'(bus.bursts_done), 32'd2);
        chk("idle_acc_base", bus.sample_base, 32'd5001);

        // acc_done during BURST_CFG is ignored
        expect_job(10, 0, 1);
        st = n_done;
        submit(32'd10, 1'b0);
        man_acc = 1'b1;
        @(negedge clk);
        man_acc = 1'b0;
        chk("cfg_acc_bursts", 32'(bus.bursts_done), 32'd0);
        chk("cfg_acc_busy", 32'(bus.busy), 32'd1);
        chk("cfg_acc_jdone", 32'(bus.job_done), 32'd0);
        repeat (3) @(negedge clk);
        chk("cfg_acc_still_busy", 32'(bus.busy), 32'd1);
        man_acc = 1'b1;
        @(negedge clk);
        man_acc = 1'b0;
        wait_done(st, 10, "done_cfg_acc");

        // reset during BURST_WAIT of run 2
        acc_auto = 1'b1;
        expect_job(12000, 0, 0);
        submit(32'd12000, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.bursts_done == 16'd1) break;
        end
        chk("rst_reach_run2", 32'(bus.bursts_done), 32'd1);
        repeat (5) @(negedge clk);
        acc_auto = 1'b0;
        rst = 1'b0;
        #1;
        check_reset("midjob_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst_runs_left", 32'(run_q.size()), 32'd1);
        run_q.delete();
        acc_auto = 1'b1;
        expect_job(10, 0, 1);
        st = n_done;
        submit(32'd10, 1'b0);
        wait_done(st, 100, "done_after_rst");

`ifdef TREES_SCHED_TIMEOUT_EN
        // watchdog: acc_done never comes
        begin
            done_t d;
            acc_auto = 1'b0;
            expect_job(7, 0, 0);
            d = '{err: 1'b1, base: 32'd0, bursts: 16'd0, after: 1'b0};
            done_q.push_back(d);
            submit(32'd7, 1'b0);
            @(posedge clk);               // entry edge into BURST_WAIT
            cnt = 0;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk); #2;
                cnt++;
                if (bus.job_done === 1'b1) break;
            end
            chk("timeout_cycles", 32'(cnt), 32'd100);
            chk("timeout_err", 32'(bus.job_error), 32'd1);
            repeat (3) @(negedge clk);
            chk("timeout_err_hold", 32'(bus.job_error), 32'd1);
            chk("timeout_idle", 32'(bus.job_ready), 32'd1);
        end
`else
        cnt = 0;
`endif

        repeat (3) @(negedge clk);
        chk("run_q_empty", 32'(run_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
